// File: rtl/fsl_msg_rx.sv
// Fabric-side FSL message reader: parses header words, streams payload beats
// with src/tag/sop/eop, drops or truncates malformed framing, keeps statistics.
module fsl_msg_rx #(
    parameter int unsigned C_MAX_LEN   = 1024,
    parameter int unsigned C_CNT_WIDTH = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_fsl_exists,
    input  logic [0:63]            i_fsl_data,
    input  logic                   i_fsl_control,
    output logic                   o_fsl_read,
    output logic                   o_msg_valid,
    input  logic                   i_msg_ready,
    output logic [0:63]            o_msg_data,
    output logic [0:15]            o_msg_src,
    output logic [0:15]            o_msg_tag,
    output logic                   o_msg_sop,
    output logic                   o_msg_eop,
    output logic                   o_msg_empty,
    output logic                   o_err_pulse,
    output logic [C_CNT_WIDTH-1:0] o_msg_cnt,
    output logic [C_CNT_WIDTH-1:0] o_drop_cnt,
    output logic [C_CNT_WIDTH-1:0] o_trunc_cnt
);

    localparam int unsigned LEN_W  = 16;
    localparam int unsigned DATA_W = 64;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(C_MAX_LEN);

    typedef enum logic [1:0] {IDLE, PAYLOAD, DISCARD} state_e;

    state_e               state_q, state_d;
    logic [LEN_W-1:0]     rem_q, rem_d;
    logic                 first_q, first_d;
    logic [LEN_W-1:0]     hsrc_q, hsrc_d;
    logic [LEN_W-1:0]     htag_q, htag_d;

    logic                 valid_q;
    logic [DATA_W-1:0]    data_q;
    logic [LEN_W-1:0]     bsrc_q, btag_q;
    logic                 sop_q, eop_q, empty_q;
    logic                 err_q;
    logic [C_CNT_WIDTH-1:0] msg_cnt_q, drop_cnt_q, trunc_cnt_q;

    logic                 slot_free_c, pop_c;
    logic [LEN_W-1:0]     hdr_src_c, hdr_tag_c, hdr_len_c;
    logic                 load_c, ld_sop_c, ld_eop_c, ld_empty_c;
    logic [DATA_W-1:0]    ld_data_c;
    logic [LEN_W-1:0]     ld_src_c, ld_tag_c;
    logic                 err_c, drop_inc_c, trunc_inc_c;
    logic                 unused_hdr_c;

    function automatic logic [C_CNT_WIDTH-1:0] sat_inc(input logic [C_CNT_WIDTH-1:0] v,
                                                       input logic en);
        return (en && (v != '1)) ? v + C_CNT_WIDTH'(1) : v;
    endfunction

    assign hdr_src_c    = i_fsl_data[0:15];
    assign hdr_tag_c    = i_fsl_data[16:31];
    assign hdr_len_c    = i_fsl_data[32:47];
    assign unused_hdr_c = ^i_fsl_data[48:63];

    // Pop when the output slot can take a beat, or unconditionally while discarding
    assign slot_free_c = !valid_q || i_msg_ready;
    assign pop_c       = i_rst_n && i_fsl_exists && ((state_q == DISCARD) || slot_free_c);
    assign o_fsl_read  = pop_c;

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state and message-context logic; any header restarts parsing from scratch
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        first_d = first_q;
        hsrc_d  = hsrc_q;
        htag_d  = htag_q;
        if (pop_c) begin
            if (i_fsl_control) begin
                if (hdr_len_c == '0) begin
                    state_d = IDLE;
                end else if (hdr_len_c > MAX_LEN) begin
                    state_d = DISCARD;
                    rem_d   = hdr_len_c;
                end else begin
                    state_d = PAYLOAD;
                    rem_d   = hdr_len_c;
                    first_d = 1'b1;
                    hsrc_d  = hdr_src_c;
                    htag_d  = hdr_tag_c;
                end
            end else begin
                case (state_q)
                    PAYLOAD: begin
                        rem_d   = rem_q - LEN_W'(1);
                        first_d = 1'b0;
                        if (rem_q == LEN_W'(1)) state_d = IDLE;
                    end
                    DISCARD: begin
                        rem_d = rem_q - LEN_W'(1);
                        if (rem_q == LEN_W'(1)) state_d = IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Output decode: beat load, error pulse and counter increments for the popped word
    always_comb begin
        load_c      = 1'b0;
        ld_data_c   = '0;
        ld_src_c    = '0;
        ld_tag_c    = '0;
        ld_sop_c    = 1'b0;
        ld_eop_c    = 1'b0;
        ld_empty_c  = 1'b0;
        err_c       = 1'b0;
        drop_inc_c  = 1'b0;
        trunc_inc_c = 1'b0;
        if (pop_c) begin
            if (i_fsl_control) begin
                if (state_q != IDLE) begin
                    trunc_inc_c = 1'b1;
                    err_c       = 1'b1;
                end
                if (hdr_len_c == '0) begin
                    // A zero-length header popped in DISCARD with a stalled slot has nowhere to go
                    if (slot_free_c) begin
                        load_c     = 1'b1;
                        ld_src_c   = hdr_src_c;
                        ld_tag_c   = hdr_tag_c;
                        ld_sop_c   = 1'b1;
                        ld_eop_c   = 1'b1;
                        ld_empty_c = 1'b1;
                    end else begin
                        drop_inc_c = 1'b1;
                    end
                end else if (hdr_len_c > MAX_LEN) begin
                    err_c = 1'b1;
                end
            end else begin
                case (state_q)
                    IDLE: begin
                        drop_inc_c = 1'b1;
                        err_c      = 1'b1;
                    end
                    PAYLOAD: begin
                        load_c    = 1'b1;
                        ld_data_c = i_fsl_data;
                        ld_src_c  = hsrc_q;
                        ld_tag_c  = htag_q;
                        ld_sop_c  = first_q;
                        ld_eop_c  = (rem_q == LEN_W'(1));
                    end
                    DISCARD: drop_inc_c = 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // Context, output beat register and saturating statistics
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rem_q       <= '0;
            first_q     <= 1'b0;
            hsrc_q      <= '0;
            htag_q      <= '0;
            valid_q     <= 1'b0;
            data_q      <= '0;
            bsrc_q      <= '0;
            btag_q      <= '0;
            sop_q       <= 1'b0;
            eop_q       <= 1'b0;
            empty_q     <= 1'b0;
            err_q       <= 1'b0;
            msg_cnt_q   <= '0;
            drop_cnt_q  <= '0;
            trunc_cnt_q <= '0;
        end else begin
            rem_q   <= rem_d;
            first_q <= first_d;
            hsrc_q  <= hsrc_d;
            htag_q  <= htag_d;
            if (load_c) begin
                valid_q <= 1'b1;
                data_q  <= ld_data_c;
                bsrc_q  <= ld_src_c;
                btag_q  <= ld_tag_c;
                sop_q   <= ld_sop_c;
                eop_q   <= ld_eop_c;
                empty_q <= ld_empty_c;
            end else if (i_msg_ready) begin
                valid_q <= 1'b0;
            end
            err_q       <= err_c;
            msg_cnt_q   <= sat_inc(msg_cnt_q, valid_q && i_msg_ready && eop_q);
            drop_cnt_q  <= sat_inc(drop_cnt_q, drop_inc_c);
            trunc_cnt_q <= sat_inc(trunc_cnt_q, trunc_inc_c);
        end
    end

    assign o_msg_valid = valid_q;
    assign o_msg_data  = data_q;
    assign o_msg_src   = bsrc_q;
    assign o_msg_tag   = btag_q;
    assign o_msg_sop   = sop_q;
    assign o_msg_eop   = eop_q;
    assign o_msg_empty = empty_q;
    assign o_err_pulse = err_q;
    assign o_msg_cnt   = msg_cnt_q;
    assign o_drop_cnt  = drop_cnt_q;
    assign o_trunc_cnt = trunc_cnt_q;

endmodule

// File: tb/tb_fsl_msg_rx.sv
// Directed bench for fsl_msg_rx: FIFO model feeds words, accepted beats are logged and compared.
module tb_fsl_msg_rx;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_fsl_exists;
    logic [0:63] i_fsl_data;
    logic        i_fsl_control;
    logic        o_fsl_read;
    logic        o_msg_valid;
    logic        i_msg_ready;
    logic [0:63] o_msg_data;
    logic [0:15] o_msg_src;
    logic [0:15] o_msg_tag;
    logic        o_msg_sop;
    logic        o_msg_eop;
    logic        o_msg_empty;
    logic        o_err_pulse;
    logic [15:0] o_msg_cnt;
    logic [15:0] o_drop_cnt;
    logic [15:0] o_trunc_cnt;

    fsl_msg_rx #(.C_MAX_LEN(1024), .C_CNT_WIDTH(16)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_fsl_exists(i_fsl_exists), .i_fsl_data(i_fsl_data), .i_fsl_control(i_fsl_control),
        .o_fsl_read(o_fsl_read),
        .o_msg_valid(o_msg_valid), .i_msg_ready(i_msg_ready),
        .o_msg_data(o_msg_data), .o_msg_src(o_msg_src), .o_msg_tag(o_msg_tag),
        .o_msg_sop(o_msg_sop), .o_msg_eop(o_msg_eop), .o_msg_empty(o_msg_empty),
        .o_err_pulse(o_err_pulse),
        .o_msg_cnt(o_msg_cnt), .o_drop_cnt(o_drop_cnt), .o_trunc_cnt(o_trunc_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [63:0] d;
        logic [15:0] s;
        logic [15:0] t;
        logic        sop;
        logic        eop;
        logic        emp;
    } beat_t;

    logic [64:0] fq[$];
    beat_t       got[$];
    int          gotc[$];
    int          popc[$];
    int          cyc_n;
    int          err_n;
    int          total;
    int          bad;
    logic        rdy;
    logic        rd;

    function automatic logic [64:0] hdr(input logic [15:0] s, input logic [15:0] t,
                                        input logic [15:0] l);
        return {1'b1, s, t, l, 16'hFFFF};
    endfunction

    function automatic logic [64:0] wrd(input logic [63:0] d);
        return {1'b0, d};
    endfunction

    function automatic beat_t mk(input logic [63:0] d, input logic [15:0] s, input logic [15:0] t,
                                 input logic sop, input logic eop, input logic emp);
        return {d, s, t, sop, eop, emp};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input int idx, input beat_t exp);
        beat_t obs;
        obs = 'x;
        if (idx < got.size()) obs = got[idx];
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: present FIFO head, log pre-edge handshakes, pop after the edge if read
    task automatic cyc();
        i_fsl_exists = (fq.size() != 0);
        if (fq.size() != 0) {i_fsl_control, i_fsl_data} = fq[0];
        else begin
            i_fsl_control = 1'b0;
            i_fsl_data    = '0;
        end
        i_msg_ready = rdy;
        #1;
        rd = o_fsl_read;
        if (o_msg_valid && i_msg_ready) begin
            got.push_back(mk(o_msg_data, o_msg_src, o_msg_tag, o_msg_sop, o_msg_eop, o_msg_empty));
            gotc.push_back(cyc_n);
        end
        if (o_err_pulse) err_n++;
        @(posedge i_clk);
        #1;
        if (rd) begin
            void'(fq.pop_front());
            popc.push_back(cyc_n);
        end
        cyc_n++;
    endtask

    task automatic drain(input int extra);
        int n;
        n = 0;
        while (fq.size() != 0 && n < 3000) begin
            cyc();
            n++;
        end
        chk("drain_timeout", 64'(fq.size()), 64'd0);
        repeat (extra) cyc();
    endtask

    task automatic clr();
        got.delete();
        gotc.delete();
        popc.delete();
        err_n = 0;
    endtask

    initial begin
        int n;
        total = 0; bad = 0; cyc_n = 0; err_n = 0; rdy = 1'b1;
        i_rst_n = 1'b0; i_fsl_exists = 1'b1; i_fsl_control = 1'b0; i_fsl_data = '0;
        i_msg_ready = 1'b1;
        #2;
        // reset state
        chk("rst_read", 64'(o_fsl_read), 64'd0);
        chk("rst_valid", 64'(o_msg_valid), 64'd0);
        chk("rst_cnts", {16'd0, o_msg_cnt, o_drop_cnt, o_trunc_cnt}, 64'd0);
        chk("rst_err", 64'(o_err_pulse), 64'd0);
        i_fsl_exists = 1'b0;
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        repeat (2) cyc();

        // basic 4-word message at full rate
        clr();
        fq.push_back(hdr(16'd3, 16'd7, 16'd4));
        fq.push_back(wrd(64'hAAAA_0000_0000_0001));
        fq.push_back(wrd(64'hBBBB_0000_0000_0002));
        fq.push_back(wrd(64'hCCCC_0000_0000_0003));
        fq.push_back(wrd(64'hDDDD_0000_0000_0004));
        drain(3);
        chk("t1_nbeats", 64'(got.size()), 64'd4);
        chk_beat("t1_b0", 0, mk(64'hAAAA_0000_0000_0001, 16'd3, 16'd7, 1'b1, 1'b0, 1'b0));
        chk_beat("t1_b1", 1, mk(64'hBBBB_0000_0000_0002, 16'd3, 16'd7, 1'b0, 1'b0, 1'b0));
        chk_beat("t1_b2", 2, mk(64'hCCCC_0000_0000_0003, 16'd3, 16'd7, 1'b0, 1'b0, 1'b0));
        chk_beat("t1_b3", 3, mk(64'hDDDD_0000_0000_0004, 16'd3, 16'd7, 1'b0, 1'b1, 1'b0));
        if (got.size() == 4 && popc.size() == 5) begin
            chk("t1_latency", 64'(gotc[0] - popc[1]), 64'd1);
            chk("t1_back2back", 64'(gotc[3] - gotc[0]), 64'd3);
        end else chk("t1_logsize", 64'(got.size()), 64'd4);
        chk("t1_msg_cnt", 64'(o_msg_cnt), 64'd1);
        chk("t1_err", 64'(err_n), 64'd0);

        // same message with B stalled for 5 cycles
        clr();
        fq.push_back(hdr(16'd3, 16'd7, 16'd4));
        fq.push_back(wrd(64'hAAAA_0000_0000_0001));
        fq.push_back(wrd(64'hBBBB_0000_0000_0002));
        fq.push_back(wrd(64'hCCCC_0000_0000_0003));
        fq.push_back(wrd(64'hDDDD_0000_0000_0004));
        n = 0;
        while (!(o_msg_valid && o_msg_data == 64'hBBBB_0000_0000_0002) && n < 50) begin
            cyc();
            n++;
        end
        chk("t2_reach_b", 64'(o_msg_data), 64'hBBBB_0000_0000_0002);
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("t2_stall_read", 64'(rd), 64'd0);
            chk("t2_stall_data", 64'(o_msg_data), 64'hBBBB_0000_0000_0002);
            chk("t2_stall_valid", 64'(o_msg_valid), 64'd1);
        end
        rdy = 1'b1;
        drain(3);
        chk("t2_nbeats", 64'(got.size()), 64'd4);
        chk_beat("t2_b1", 1, mk(64'hBBBB_0000_0000_0002, 16'd3, 16'd7, 1'b0, 1'b0, 1'b0));
        chk_beat("t2_b2", 2, mk(64'hCCCC_0000_0000_0003, 16'd3, 16'd7, 1'b0, 1'b0, 1'b0));
        chk_beat("t2_b3", 3, mk(64'hDDDD_0000_0000_0004, 16'd3, 16'd7, 1'b0, 1'b1, 1'b0));
        if (got.size() == 4) chk("t2_cd_b2b", 64'(gotc[3] - gotc[2]), 64'd1);
        chk("t2_msg_cnt", 64'(o_msg_cnt), 64'd2);

        // zero-length message
        clr();
        fq.push_back(hdr(16'h0011, 16'h0022, 16'd0));
        drain(3);
        chk("t3_nbeats", 64'(got.size()), 64'd1);
        chk_beat("t3_b0", 0, mk(64'd0, 16'h0011, 16'h0022, 1'b1, 1'b1, 1'b1));
        chk("t3_msg_cnt", 64'(o_msg_cnt), 64'd3);

        // oversize message discarded, following message delivered
        clr();
        fq.push_back(hdr(16'd9, 16'd9, 16'd1025));
        for (int i = 0; i < 1025; i++) fq.push_back(wrd(64'(i)));
        fq.push_back(hdr(16'd5, 16'd9, 16'd1));
        fq.push_back(wrd(64'h1234_5678_9ABC_DEF0));
        drain(3);
        chk("t4_nbeats", 64'(got.size()), 64'd1);
        chk_beat("t4_b0", 0, mk(64'h1234_5678_9ABC_DEF0, 16'd5, 16'd9, 1'b1, 1'b1, 1'b0));
        chk("t4_drop_cnt", 64'(o_drop_cnt), 64'd1025);
        chk("t4_err", 64'(err_n), 64'd1);
        chk("t4_msg_cnt", 64'(o_msg_cnt), 64'd4);
        chk("t4_trunc_cnt", 64'(o_trunc_cnt), 64'd0);

        // premature header truncates the previous message
        clr();
        fq.push_back(hdr(16'd1, 16'd2, 16'd3));
        fq.push_back(wrd(64'h0000_0000_0000_00A1));
        fq.push_back(hdr(16'd4, 16'd6, 16'd1));
        fq.push_back(wrd(64'h0000_0000_0000_00B2));
        drain(3);
        chk("t5_nbeats", 64'(got.size()), 64'd2);
        chk_beat("t5_b0", 0, mk(64'h0000_0000_0000_00A1, 16'd1, 16'd2, 1'b1, 1'b0, 1'b0));
        chk_beat("t5_b1", 1, mk(64'h0000_0000_0000_00B2, 16'd4, 16'd6, 1'b1, 1'b1, 1'b0));
        chk("t5_trunc_cnt", 64'(o_trunc_cnt), 64'd1);
        chk("t5_msg_cnt", 64'(o_msg_cnt), 64'd5);
        chk("t5_err", 64'(err_n), 64'd1);

        // stray word in IDLE
        clr();
        fq.push_back(wrd(64'hDEAD_BEEF_0000_0000));
        drain(3);
        chk("t6_stray_nbeats", 64'(got.size()), 64'd0);
        chk("t6_drop_cnt", 64'(o_drop_cnt), 64'd1026);
        chk("t6_err", 64'(err_n), 64'd1);

        // async reset in the middle of a payload
        clr();
        rdy = 1'b0;
        fq.push_back(hdr(16'd8, 16'd8, 16'd4));
        fq.push_back(wrd(64'h0000_0000_0000_0C01));
        fq.push_back(wrd(64'h0000_0000_0000_0C02));
        n = 0;
        while (!o_msg_valid && n < 20) begin
            cyc();
            n++;
        end
        chk("t6_pre_valid", 64'(o_msg_valid), 64'd1);
        #2;
        i_rst_n = 1'b0;
        i_fsl_exists = 1'b1;
        #1;
        chk("t6_rst_valid", 64'(o_msg_valid), 64'd0);
        chk("t6_rst_beat", {o_msg_data}, 64'd0);
        chk("t6_rst_flags", {60'd0, o_msg_sop, o_msg_eop, o_msg_empty, o_err_pulse}, 64'd0);
        chk("t6_rst_cnts", {16'd0, o_msg_cnt, o_drop_cnt, o_trunc_cnt}, 64'd0);
        chk("t6_rst_read", 64'(o_fsl_read), 64'd0);
        fq.delete();
        rdy = 1'b1;
        i_fsl_exists = 1'b0;
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        clr();
        fq.push_back(hdr(16'h000A, 16'h000B, 16'd1));
        fq.push_back(wrd(64'h0000_0000_0000_0E0E));
        drain(3);
        chk("t6_post_nbeats", 64'(got.size()), 64'd1);
        chk_beat("t6_post_b0", 0, mk(64'h0000_0000_0000_0E0E, 16'h000A, 16'h000B, 1'b1, 1'b1, 1'b0));
        chk("t6_post_msg_cnt", 64'(o_msg_cnt), 64'd1);
        chk("t6_post_drop_cnt", 64'(o_drop_cnt), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
